// File: rtl/rca6_seq_ctrl_if.sv
// rca6_seq_ctrl_if: client-side start/operand/result bundle for the multi-limb adder sequencer
interface rca6_seq_ctrl_if #(parameter int LIMBS = 4);
   localparam int W = 6 * LIMBS;
   logic start, sub, ready, done, cout, ovf;
   logic [W-1:0] a, b, sum;
   modport master (output start, sub, a, b, input ready, done, sum, cout, ovf);
   modport slave (input start, sub, a, b, output ready, done, sum, cout, ovf);
endinterface

// File: rtl/rca6_seq_ctrl.sv
// rca6_seq_ctrl: time-shares one external 6-bit adder for 6*LIMBS-bit add/sub, LSB limb first
module rca6_seq_ctrl #(parameter int LIMBS = 4) (
   input  logic             clk,
   input  logic             rst_n,
   rca6_seq_ctrl_if.slave   bus,
   output logic [5:0]       add_a,
   output logic [5:0]       add_b,
   output logic             add_cin,
   input  logic [5:0]       add_so,
   input  logic             add_cout
);
   localparam int W = 6 * LIMBS;
   localparam int IW = $clog2(LIMBS);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, nxt;
   logic [W-1:0] a_reg, b_reg;
   logic carry;
   logic [IW-1:0] idx;
   logic last;
   assign last = idx == IW'(LIMBS - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      bus.ready = 1'b0;
      bus.done = 1'b0;
      add_a = '0;
      add_b = '0;
      add_cin = 1'b0;
      nxt = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
      bus.ready = state == IDLE;
      bus.done = state == DONE;
      add_a = state == RUN ? a_reg[6*idx +: 6] : '0;
      add_b = state == RUN ? b_reg[6*idx +: 6] : '0;
      add_cin = state == RUN && carry;
   end
   // subtraction is A + ~B + 1: invert B once at launch and seed the carry register with 1
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         idx <= '0;
         bus.sum <= '0;
         bus.cout <= 1'b0;
         bus.ovf <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         a_reg <= bus.a;
         b_reg <= bus.sub ? ~bus.b : bus.b;
         carry <= bus.sub;
         idx <= '0;
      end else if (state == RUN) begin
         bus.sum[6*idx +: 6] <= add_so;
         carry <= add_cout;
         idx <= last ? idx : idx + IW'(1);
         if (last) begin
            bus.cout <= add_cout;
            bus.ovf <= (a_reg[W-1] == b_reg[W-1]) && (add_so[5] != a_reg[W-1]);
         end
      end
endmodule

// File: tb/tb_rca6_seq_ctrl.sv
// tb_rca6_seq_ctrl: random + directed checks of the limb sequencer against an arithmetic model
module tb_rca6_seq_ctrl;
   localparam int L = 4;
   localparam int W = 6 * L;
   logic clk = 0, rst_n = 1;
   always #5 clk = ~clk;
   rca6_seq_ctrl_if #(.LIMBS(4)) b4 ();
   rca6_seq_ctrl_if #(.LIMBS(2)) b2 ();
   logic [5:0] x_a, x_b, x_so, y_a, y_b, y_so;
   logic x_ci, x_co, y_ci, y_co;
   assign {x_co, x_so} = {1'b0, x_a} + {1'b0, x_b} + 7'(x_ci);
   assign {y_co, y_so} = {1'b0, y_a} + {1'b0, y_b} + 7'(y_ci);
   rca6_seq_ctrl #(.LIMBS(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4), .add_a(x_a), .add_b(x_b),
      .add_cin(x_ci), .add_so(x_so), .add_cout(x_co));
   rca6_seq_ctrl #(.LIMBS(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2), .add_a(y_a), .add_b(y_b),
      .add_cin(y_ci), .add_so(y_so), .add_cout(y_co));
   int total = 0, bad = 0;
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, act, exp);
      end
   endtask
   // model: ph 0 = idle, 1..L = working on limb ph-1, L+1 = done cycle
   int ph = 0;
   logic [W-1:0] ea = '0, eb = '0, ms = '0;
   logic es = 0, mc = 0, mo = 0;
   logic [W:0] full = '0;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ph = 0; ms = '0; mc = 0; mo = 0; ea = '0; eb = '0; es = 0;
      end else if (ph == 0) begin
         if (b4.start) begin
            ea = b4.a;
            eb = b4.sub ? ~b4.b : b4.b;
            es = b4.sub;
            full = {1'b0, ea} + {1'b0, eb} + (W+1)'(es);
            ph = 1;
         end
      end else if (ph <= L) begin
         ms[6*(ph-1) +: 6] = full[6*(ph-1) +: 6];
         if (ph == L) begin
            mc = full[W];
            mo = (ea[W-1] == eb[W-1]) && (full[W-1] != ea[W-1]);
         end
         ph++;
      end else ph = 0;
   function automatic logic cin_at(input int i);
      logic [W:0] m, s;
      m = ({{W{1'b0}}, 1'b1} << (6 * i)) - 1;
      s = ({1'b0, ea} & m) + ({1'b0, eb} & m) + (W+1)'(es);
      return s[6*i];
   endfunction
   always @(negedge clk) begin
      logic run;
      run = ph >= 1 && ph <= L;
      chk("ctl", {b4.ready, b4.done}, {ph == 0, ph == L + 1});
      chk("adder", {x_a, x_b, x_ci},
          run ? {ea[6*(ph-1) +: 6], eb[6*(ph-1) +: 6], cin_at(ph - 1)} : 13'd0);
      chk("result", {b4.cout, b4.ovf, b4.sum}, {mc, mo, ms});
   end
   task automatic op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] xs, input logic xc, input logic xo, input bit poke,
                     output logic [L-1:0] cins, output logic [5:0] b0);
      int k;
      k = 0;
      @(negedge clk);
      while (!b4.ready && k < 30) begin @(negedge clk); k++; end
      chk("ready_wait", b4.ready, 1);
      b4.start = 1; b4.sub = s; b4.a = a; b4.b = b;
      @(negedge clk);
      b4.start = 0;
      k = 1; cins = '0; b0 = '0;
      while (!b4.done && k < 30) begin
         if (k <= L) cins[k-1] = x_ci;
         if (k == 1) b0 = x_b;
         b4.start = poke && k == 2;
         @(negedge clk);
         k++;
      end
      b4.start = 0;
      chk("latency", k, L + 1);
      chk("sum", b4.sum, xs);
      chk("cout", b4.cout, xc);
      chk("ovf", b4.ovf, xo);
   endtask
   initial begin
      logic [L-1:0] cins;
      logic [5:0] b0;
      int k, n;
      b4.start = 0; b4.sub = 0; b4.a = '0; b4.b = '0;
      b2.start = 0; b2.sub = 0; b2.a = '0; b2.b = '0;
      #2 rst_n = 0;
      #1 chk("rst_ready", {b4.ready, b4.done}, 2'b10);
      chk("rst_res", {b4.cout, b4.ovf, b4.sum}, '0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      op(0, 24'h000001, 24'hFFFFFF, 24'h000000, 1, 0, 0, cins, b0);
      chk("cin_seq", cins, 4'b1110);
      op(1, 24'h000005, 24'h000007, 24'hFFFFFE, 0, 0, 0, cins, b0);
      chk("sub_cin0", cins[0], 1);
      chk("sub_b0", b0, 6'h38);
      op(0, 24'h7FFFFF, 24'h000001, 24'h800000, 0, 1, 0, cins, b0);
      op(1, 24'h800000, 24'h000001, 24'h7FFFFF, 1, 1, 0, cins, b0);
      op(0, 24'h00ABCD, 24'h001111, 24'h00BCDE, 0, 0, 1, cins, b0);
      n = 0;
      repeat (L + 3) begin @(negedge clk); n += int'(b4.done); end
      chk("extra_done", n, 0);
      b4.start = 1; b4.sub = 0; b4.a = 24'h123456; b4.b = 24'h111111;
      k = 0;
      do begin @(negedge clk); k++; end while (!b4.done && k < 30);
      chk("hold_sum1", b4.sum, 24'h234567);
      k = 0;
      do begin
         @(negedge clk); k++;
         if (k == 1) chk("hold_ready", b4.ready, 1);
         if (k == 2) chk("hold_busy", b4.ready, 0);
         if (!b4.done) chk("hold_keep", b4.sum, 24'h234567);
      end while (!b4.done && k < 30);
      chk("hold_period", k, L + 2);
      b4.start = 0;
      op(0, 24'h0F0F0F, 24'h010101, 24'h101010, 0, 0, 0, cins, b0);
      @(negedge clk);
      b4.start = 1; b4.sub = 0; b4.a = 24'h0F0F0F; b4.b = 24'h010101;
      @(negedge clk); b4.start = 0;
      @(negedge clk);
      #2 rst_n = 0;
      #1 chk("mid_rst_ctl", {b4.ready, b4.done}, 2'b10);
      chk("mid_rst_res", {b4.cout, b4.ovf, b4.sum}, '0);
      chk("mid_rst_adder", {x_a, x_b, x_ci}, '0);
      n = 0;
      repeat (3) begin @(negedge clk); n += int'(b4.done); end
      chk("rst_no_done", n, 0);
      rst_n = 1;
      op(1, 24'h100000, 24'h000001, 24'h0FFFFF, 1, 0, 0, cins, b0);
      repeat (400) begin
         @(negedge clk);
         b4.start = $urandom_range(0, 2) == 0;
         b4.sub = 1'($urandom);
         b4.a = $urandom_range(0, 5) == 0 ? 24'h800000 : W'($urandom);
         b4.b = $urandom_range(0, 5) == 0 ? 24'hFFFFFF : W'($urandom);
      end
      b4.start = 0;
      repeat (L + 3) @(negedge clk);
      chk("l2_idle", {b2.ready, y_a, y_b, y_ci}, 14'h2000);
      b2.start = 1; b2.sub = 0; b2.a = 12'hFFF; b2.b = 12'h001;
      @(negedge clk);
      b2.start = 0;
      chk("l2_limb0", {y_a, y_b, y_ci}, {6'h3F, 6'h01, 1'b0});
      k = 1;
      while (!b2.done && k < 30) begin @(negedge clk); k++; end
      chk("l2_latency", k, 3);
      chk("l2_done_adder", {y_a, y_b, y_ci}, '0);
      chk("l2_res", {b2.cout, b2.sum}, {1'b1, 12'h000});
      @(negedge clk);
      chk("l2_back_idle", {b2.ready, y_a, y_b, y_ci}, 14'h2000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
